// File: rtl/axi_default_slave.sv
// axi_default_slave
//   Default AXI4 slave for addresses that decode to no mapped slave. It accepts
//   every burst and answers with DECERR: a write burst is drained and gets one
//   B response, and a read burst gets ARLEN+1 zero-data R beats. The write and
//   read channels run independently, with one outstanding transaction on each.
//
// Optional feature (macro DEFAULT_SLAVE_ERR_LOG_EN):
//   err_addr_o holds the address of the most recently accepted AW or AR. When
//   both are accepted in the same cycle, the AW address is kept. err_cnt_o
//   counts accepted address handshakes and saturates at all-ones.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   aw*_i / awready_o        write address channel (awlen_i is ignored)
//   w*_i / wready_o          write data channel (data is discarded)
//   b*_o / bready_i          write response channel
//   ar*_i / arready_o        read address channel
//   r*_o / rready_i          read data channel
//   err_addr_o, err_cnt_o    error log outputs (only with the macro defined)
//
// States:
//   W_IDLE | waiting for an AW, awready_o=1
//   W_DATA | draining W beats until WLAST, wready_o=1
//   W_RESP | presenting the DECERR B response
//   R_IDLE | waiting for an AR, arready_o=1
//   R_DATA | returning DECERR beats until the captured length is reached
module axi_default_slave #(
  parameter int IdWidth   = 4,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IdWidth-1:0]   awid_i,
  input  logic [AddrWidth-1:0] awaddr_i,
  input  logic [7:0]           awlen_i,
  input  logic                 awvalid_i,
  output logic                 awready_o,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 wlast_i,
  input  logic                 wvalid_i,
  output logic                 wready_o,
  output logic [IdWidth-1:0]   bid_o,
  output logic [1:0]           bresp_o,
  output logic                 bvalid_o,
  input  logic                 bready_i,
  input  logic [IdWidth-1:0]   arid_i,
  input  logic [AddrWidth-1:0] araddr_i,
  input  logic [7:0]           arlen_i,
  input  logic                 arvalid_i,
  output logic                 arready_o,
  output logic [IdWidth-1:0]   rid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic [1:0]           rresp_o,
  output logic                 rlast_o,
  output logic                 rvalid_o,
  input  logic                 rready_i
`ifdef DEFAULT_SLAVE_ERR_LOG_EN
  ,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic [CntWidth-1:0]  err_cnt_o
`endif
);

  localparam logic [1:0] RespDecErr = 2'b11;
  localparam logic [1:0] RespOkay   = 2'b00;

  // ---------------------------------------------------------------- write
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  w_state_t           w_state, w_state_next;
  logic [IdWidth-1:0] bid_next;

  always_comb begin
    w_state_next = w_state;
    bid_next     = bid_o;
    case (w_state)
      W_IDLE: begin
        if (awvalid_i) begin
          w_state_next = W_DATA;
          bid_next     = awid_i;
        end
      end
      W_DATA: begin
        if (wvalid_i && wlast_i) w_state_next = W_RESP;
      end
      W_RESP: begin
        if (bready_i) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they are flops of their own.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state   <= W_IDLE;
      awready_o <= 1'b1;
      wready_o  <= 1'b0;
      bvalid_o  <= 1'b0;
      bresp_o   <= RespOkay;
      bid_o     <= '0;
    end else begin
      w_state   <= w_state_next;
      awready_o <= (w_state_next == W_IDLE);
      wready_o  <= (w_state_next == W_DATA);
      bvalid_o  <= (w_state_next == W_RESP);
      bresp_o   <= (w_state_next == W_RESP) ? RespDecErr : RespOkay;
      bid_o     <= bid_next;
    end
  end

  // ----------------------------------------------------------------- read
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  r_state_t           r_state, r_state_next;
  logic [IdWidth-1:0] rid_next;
  logic [7:0]         r_len, r_len_next;
  logic [7:0]         r_cnt, r_cnt_next;
  logic               rlast_next;

  always_comb begin
    r_state_next = r_state;
    rid_next     = rid_o;
    r_len_next   = r_len;
    r_cnt_next   = r_cnt;
    case (r_state)
      R_IDLE: begin
        if (arvalid_i) begin
          r_state_next = R_DATA;
          rid_next     = arid_i;
          r_len_next   = arlen_i;
          r_cnt_next   = 8'd0;
        end
      end
      R_DATA: begin
        if (rready_i) begin
          // The counter is not advanced on the last beat, so a 256-beat
          // burst never wraps it.
          if (rlast_o) r_state_next = R_IDLE;
          else         r_cnt_next   = r_cnt + 8'd1;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
    rlast_next = (r_state_next == R_DATA) && (r_cnt_next == r_len_next);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= R_IDLE;
      arready_o <= 1'b1;
      rvalid_o  <= 1'b0;
      rresp_o   <= RespOkay;
      rlast_o   <= 1'b0;
      rid_o     <= '0;
      r_len     <= 8'd0;
      r_cnt     <= 8'd0;
    end else begin
      r_state   <= r_state_next;
      arready_o <= (r_state_next == R_IDLE);
      rvalid_o  <= (r_state_next == R_DATA);
      rresp_o   <= (r_state_next == R_DATA) ? RespDecErr : RespOkay;
      rlast_o   <= rlast_next;
      rid_o     <= rid_next;
      r_len     <= r_len_next;
      r_cnt     <= r_cnt_next;
    end
  end

  assign rdata_o = '0;

  // ------------------------------------------------------------ error log
`ifdef DEFAULT_SLAVE_ERR_LOG_EN
  logic              aw_hs, ar_hs;
  logic [CntWidth:0] cnt_sum;

  assign aw_hs   = awvalid_i && awready_o;
  assign ar_hs   = arvalid_i && arready_o;
  // One extra bit catches the carry for saturation.
  assign cnt_sum = {1'b0, err_cnt_o} + (CntWidth+1)'(aw_hs) + (CntWidth+1)'(ar_hs);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_addr_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      if (aw_hs)      err_addr_o <= awaddr_i;
      else if (ar_hs) err_addr_o <= araddr_i;
      err_cnt_o <= cnt_sum[CntWidth] ? {CntWidth{1'b1}} : cnt_sum[CntWidth-1:0];
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{awlen_i, wdata_i};
`else
  logic unused_inputs;
  assign unused_inputs = ^{awlen_i, wdata_i, awaddr_i, araddr_i};
`endif

endmodule

// File: tb/tb_axi_default_slave.sv
// Testbench for axi_default_slave: a cycle table for the write channel, short
// hand-written sequences for the read and corner cases, and randomized traffic
// checked against a queue-based transaction model.
module tb_axi_default_slave;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready_o;
  logic [31:0] wdata;
  logic        wlast;
  logic        wvalid;
  logic        wready_o;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready_o;
  logic [3:0]  rid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic        rvalid_o;
  logic        rready;
`ifdef DEFAULT_SLAVE_ERR_LOG_EN
  logic [31:0] err_addr_o;
  logic [15:0] err_cnt_o;
`endif

  axi_default_slave dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awvalid_i(awvalid), .awready_o(awready_o),
    .wdata_i(wdata), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arvalid_i(arvalid), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o),
    .rready_i(rready)
`ifdef DEFAULT_SLAVE_ERR_LOG_EN
    , .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0;
    wvalid = 1'b0; wlast = 1'b0; wdata = '0; bready = 1'b0;
    arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; rready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  // Write-channel cycle table: inputs before an edge, expected outputs after it.
  typedef struct packed {
    logic       awvalid;
    logic [3:0] awid;
    logic       wvalid;
    logic       wlast;
    logic       bready;
    logic       e_awready;
    logic       e_wready;
    logic       e_bvalid;
    logic [3:0] e_bid;
    logic [1:0] e_bresp;
  } wvec_t;

  wvec_t vecs[$];

  function automatic wvec_t mk(input logic av, input logic [3:0] id, input logic wv,
                               input logic wl, input logic br, input logic ea,
                               input logic ew, input logic eb, input logic [3:0] ebid,
                               input logic [1:0] eresp);
    wvec_t v;
    v = '{av, id, wv, wl, br, ea, ew, eb, ebid, eresp};
    return v;
  endfunction

  typedef struct packed {
    logic [3:0] id;
    logic       last;
  } rbeat_t;

  initial begin
    int     beats;
    logic   aw_f, w_f, b_f, ar_f, r_f, wl_pre;
    logic [31:0] awaddr_pre, araddr_pre;
    logic [3:0]  awid_pre, arid_pre;
    logic [7:0]  arlen_pre;
    int     b_q[$];
    rbeat_t r_q[$];
    int     w_q[$];
    int     wl_done;
    rbeat_t eb;
    logic [31:0] m_addr;
    logic [16:0] m_cnt;
    bit     issuing;
    int     cyc;

    do_reset();
    check("reset awready", 64'(awready_o), 64'd1);
    check("reset arready", 64'(arready_o), 64'd1);
    check("reset wready", 64'(wready_o), 64'd0);
    check("reset bvalid", 64'(bvalid_o), 64'd0);
    check("reset rvalid", 64'(rvalid_o), 64'd0);
    check("reset rlast", 64'(rlast_o), 64'd0);
    check("reset resp", 64'({bresp_o, rresp_o}), 64'd0);
    check("reset ids", 64'({bid_o, rid_o}), 64'd0);

    // Burst of 4 with bready high, then W-before-AW with bready held low.
    vecs.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 2'd0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 2'd0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 2'd0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 2'd0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 2'd3));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 2'd0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 2'd0));
    vecs.push_back(mk(1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 2'd0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 2'd3));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 2'd3));
    vecs.push_back(mk(1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 2'd0));
    vecs.push_back(mk(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 2'd0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 2'd3));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 2'd0));

    foreach (vecs[i]) begin
      awvalid = vecs[i].awvalid; awid = vecs[i].awid; awlen = 8'd3;
      wvalid = vecs[i].wvalid; wlast = vecs[i].wlast; bready = vecs[i].bready;
      step();
      check($sformatf("vec%0d awready", i), 64'(awready_o), 64'(vecs[i].e_awready));
      check($sformatf("vec%0d wready", i), 64'(wready_o), 64'(vecs[i].e_wready));
      check($sformatf("vec%0d bvalid", i), 64'(bvalid_o), 64'(vecs[i].e_bvalid));
      check($sformatf("vec%0d bid", i), 64'(bid_o), 64'(vecs[i].e_bid));
      check($sformatf("vec%0d bresp", i), 64'(bresp_o), 64'(vecs[i].e_bresp));
      check($sformatf("vec%0d rvalid", i), 64'(rvalid_o), 64'd0);
    end
    idle_inputs();

    // AR id=5 len=7 with rready high: 8 back-to-back beats.
    arvalid = 1'b1; arid = 4'd5; arlen = 8'd7; rready = 1'b1;
    step();
    arvalid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      check($sformatf("ar8 beat%0d rvalid", b), 64'(rvalid_o), 64'd1);
      check($sformatf("ar8 beat%0d rid", b), 64'(rid_o), 64'd5);
      check($sformatf("ar8 beat%0d rdata", b), 64'(rdata_o), 64'd0);
      check($sformatf("ar8 beat%0d rresp", b), 64'(rresp_o), 64'd3);
      check($sformatf("ar8 beat%0d rlast", b), 64'(rlast_o), 64'(b == 7));
      check($sformatf("ar8 beat%0d arready", b), 64'(arready_o), 64'd0);
      step();
    end
    check("ar8 end arready", 64'(arready_o), 64'd1);
    check("ar8 end rvalid", 64'(rvalid_o), 64'd0);
    check("ar8 end rresp", 64'(rresp_o), 64'd0);
    check("ar8 end rid hold", 64'(rid_o), 64'd5);

    // AR len=0 with rready 0,0,1: single beat held stable.
    arvalid = 1'b1; arid = 4'd10; arlen = 8'd0; rready = 1'b0;
    step();
    arvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ar1 hold%0d rvalid", k), 64'(rvalid_o), 64'd1);
      check($sformatf("ar1 hold%0d rlast", k), 64'(rlast_o), 64'd1);
      check($sformatf("ar1 hold%0d rid", k), 64'(rid_o), 64'd10);
      check($sformatf("ar1 hold%0d rresp", k), 64'(rresp_o), 64'd3);
      rready = (k == 2);
      step();
    end
    check("ar1 end rvalid", 64'(rvalid_o), 64'd0);
    check("ar1 end arready", 64'(arready_o), 64'd1);
    rready = 1'b0;

    // AR len=255: 256 beats, rlast only on the final one.
    arvalid = 1'b1; arid = 4'd6; arlen = 8'd255; rready = 1'b1;
    step();
    arvalid = 1'b0;
    beats = 0;
    for (int c = 0; c < 300; c++) begin
      if (rvalid_o) begin
        beats++;
        if (rlast_o) begin
          step();
          break;
        end
      end
      step();
    end
    check("ar256 beat count", 64'(beats), 64'd256);
    check("ar256 end rvalid", 64'(rvalid_o), 64'd0);
    rready = 1'b0;

    // Simultaneous AW and AR.
    do_reset();
    awvalid = 1'b1; awid = 4'd2; awaddr = 32'hdead_0040;
    arvalid = 1'b1; arid = 4'd9; arlen = 8'd1; araddr = 32'hbeef_0080;
    step();
    awvalid = 1'b0; arvalid = 1'b0;
    check("sim awready", 64'(awready_o), 64'd0);
    check("sim arready", 64'(arready_o), 64'd0);
    check("sim wready", 64'(wready_o), 64'd1);
    check("sim rvalid", 64'(rvalid_o), 64'd1);
    check("sim rid", 64'(rid_o), 64'd9);
    check("sim rlast beat1", 64'(rlast_o), 64'd0);
`ifdef DEFAULT_SLAVE_ERR_LOG_EN
    check("sim err_cnt", 64'(err_cnt_o), 64'd2);
    check("sim err_addr", 64'(err_addr_o), 64'h dead_0040);
`endif
    rready = 1'b1;
    step();
    check("sim rlast beat2", 64'(rlast_o), 64'd1);
    check("sim rid beat2", 64'(rid_o), 64'd9);
    step();
    check("sim r done", 64'(rvalid_o), 64'd0);
    check("sim w still draining", 64'(wready_o), 64'd1);
    rready = 1'b0;
    wvalid = 1'b1; wlast = 1'b1;
    step();
    wvalid = 1'b0; wlast = 1'b0;
    check("sim bvalid", 64'(bvalid_o), 64'd1);
    check("sim bid", 64'(bid_o), 64'd2);
    check("sim bresp", 64'(bresp_o), 64'd3);
    bready = 1'b1;
    step();
    check("sim b done", 64'(bvalid_o), 64'd0);
    check("sim awready after b", 64'(awready_o), 64'd1);
    bready = 1'b0;

    // Reset in the middle of a 4-beat read burst.
    arvalid = 1'b1; arid = 4'd4; arlen = 8'd3; rready = 1'b1;
    step();
    arvalid = 1'b0;
    step();
    step();
    check("midrst pre rvalid", 64'(rvalid_o), 64'd1);
    rst_ni = 1'b0;
    step();
    check("midrst rvalid", 64'(rvalid_o), 64'd0);
    check("midrst arready", 64'(arready_o), 64'd1);
    check("midrst awready", 64'(awready_o), 64'd1);
    check("midrst rlast", 64'(rlast_o), 64'd0);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("midrst after%0d rvalid", k), 64'(rvalid_o), 64'd0);
    end
    rready = 1'b0;

    // Randomized traffic against a transaction-level model.
    do_reset();
    wl_done = 0;
    m_addr = '0;
    m_cnt = '0;
    issuing = 1'b1;
    cyc = 0;
    while (cyc < 6000) begin
      if (cyc == 3000) issuing = 1'b0;
      if (!issuing && b_q.size() == 0 && r_q.size() == 0 && w_q.size() == 0 &&
          !awvalid && !arvalid && !wvalid) break;

      aw_f = awvalid && awready_o;
      w_f  = wvalid && wready_o;
      b_f  = bvalid_o && bready;
      ar_f = arvalid && arready_o;
      r_f  = rvalid_o && rready;
      wl_pre = wlast;
      awid_pre = awid; awaddr_pre = awaddr;
      arid_pre = arid; araddr_pre = araddr; arlen_pre = arlen;

      if (!bvalid_o) check("rand bresp idle", 64'(bresp_o), 64'd0);
      if (!rvalid_o) check("rand rresp idle", 64'(rresp_o), 64'd0);
      if (r_f) begin
        if (r_q.size() == 0) check("rand unexpected r beat", 64'd1, 64'd0);
        else begin
          eb = r_q.pop_front();
          check("rand rid", 64'(rid_o), 64'(eb.id));
          check("rand rlast", 64'(rlast_o), 64'(eb.last));
          check("rand rdata", 64'(rdata_o), 64'd0);
          check("rand rresp", 64'(rresp_o), 64'd3);
        end
      end
      if (b_f) begin
        if (b_q.size() == 0 || wl_done == 0) check("rand unexpected b", 64'd1, 64'd0);
        else begin
          check("rand bid", 64'(bid_o), 64'(b_q.pop_front()));
          check("rand bresp", 64'(bresp_o), 64'd3);
          wl_done--;
        end
      end
      if (ar_f)
        for (int k = 0; k <= int'(arlen_pre); k++) r_q.push_back('{arid_pre, k == int'(arlen_pre)});
      if (aw_f) b_q.push_back(int'(awid_pre));
      if (w_f && wl_pre) wl_done++;
      if (aw_f) m_addr = awaddr_pre;
      else if (ar_f) m_addr = araddr_pre;
      m_cnt = m_cnt + 17'(aw_f) + 17'(ar_f);
      if (m_cnt > 17'h0ffff) m_cnt = 17'h0ffff;

      step();
      cyc++;

`ifdef DEFAULT_SLAVE_ERR_LOG_EN
      check("rand err_cnt", 64'(err_cnt_o), 64'(m_cnt[15:0]));
      check("rand err_addr", 64'(err_addr_o), 64'(m_addr));
`endif

      if (aw_f) awvalid = 1'b0;
      if (!awvalid && issuing && $urandom_range(3) == 0) begin
        awvalid = 1'b1;
        awid = 4'($urandom);
        awaddr = $urandom;
        awlen = 8'($urandom);
        w_q.push_back(int'($urandom_range(1, 4)));
      end
      if (w_f) begin
        w_q[0] = w_q[0] - 1;
        if (w_q[0] == 0) void'(w_q.pop_front());
        wvalid = 1'b0;
      end
      if (!wvalid && w_q.size() > 0 && $urandom_range(1) == 1) begin
        wvalid = 1'b1;
        wdata = $urandom;
      end
      wlast = wvalid && (w_q.size() > 0) && (w_q[0] == 1);

      if (ar_f) arvalid = 1'b0;
      if (!arvalid && issuing && $urandom_range(3) == 0) begin
        arvalid = 1'b1;
        arid = 4'($urandom);
        araddr = $urandom;
        arlen = 8'($urandom_range(0, 7));
      end
      bready = issuing ? 1'($urandom_range(1)) : 1'b1;
      rready = issuing ? 1'($urandom_range(1)) : 1'b1;
    end
    check("rand drained b", 64'(b_q.size()), 64'd0);
    check("rand drained r", 64'(r_q.size()), 64'd0);
    check("rand drained w", 64'(w_q.size() + wl_done), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_default_slave.md
Name: axi_default_slave

Overview:
- Error-responding AXI4 slave behind the interconnect address decoder.
- Any AW/AR transaction whose address decodes to no mapped slave (decoder error_o=1) is routed here.
- Write bursts: all beats are drained, then one B response with DECERR is returned.
- Read bursts: ARLEN+1 R beats with DECERR and zero data are returned.
- Write and read channels are fully independent.

Parameters:
- IdWidth, 4, width of AXI ID fields.
- DataWidth, 32, width of RDATA/WDATA.
- AddrWidth, 32, width of AWADDR/ARADDR (used only by the error log).
- CntWidth, 16, width of the error counter (used only by the error log).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- awid_i  in  IdWidth  write ID
- awaddr_i  in  AddrWidth  write address
- awlen_i  in  8  write burst length-1
- awvalid_i  in  1  AW valid
- awready_o  out  1  AW ready
- wdata_i  in  DataWidth  write data (discarded)
- wlast_i  in  1  last write beat
- wvalid_i  in  1  W valid
- wready_o  out  1  W ready
- bid_o  out  IdWidth  response ID
- bresp_o  out  2  write response
- bvalid_o  out  1  B valid
- bready_i  in  1  B ready
- arid_i  in  IdWidth  read ID
- araddr_i  in  AddrWidth  read address
- arlen_i  in  8  read burst length-1
- arvalid_i  in  1  AR valid
- arready_o  out  1  AR ready
- rid_o  out  IdWidth  read ID
- rdata_o  out  DataWidth  read data
- rresp_o  out  2  read response
- rlast_o  out  1  last read beat
- rvalid_o  out  1  R valid
- rready_i  in  1  R ready

Behaviour:
- Reset: clk_i and rst_ni only; reset is synchronous, active-low. While rst_ni=0 at a clk_i edge, both FSMs go to IDLE and all outputs are driven 0 except awready_o=1 and arready_o=1. Reset mid-burst abandons the burst; no response is issued afterwards.
- Write FSM:
  - W_IDLE: awready_o=1, wready_o=0. On awvalid_i&awready_o, capture awid_i into bid_o → W_DATA.
  - W_DATA: awready_o=0, wready_o=1. Each wvalid_i beat is accepted and discarded. On wvalid_i&wlast_i → W_RESP. The number of beats is set by wlast_i only; awlen_i is ignored.
  - W_RESP: bvalid_o=1, bresp_o=2'b11 (DECERR), bid_o stable. On bready_i → W_IDLE.
- Write latency and ordering:
  - wready_o rises the cycle after the AW handshake.
  - bvalid_o rises the cycle after the WLAST handshake.
  - W beats presented before AW are stalled (wready_o=0), which is legal AXI.
  - The next AW can be accepted the cycle after the B handshake.
- Read FSM:
  - R_IDLE: arready_o=1, rvalid_o=0. On handshake, capture arid_i and arlen_i; clear the 8-bit beat counter → R_DATA.
  - R_DATA: arready_o=0, rvalid_o=1, rdata_o=0, rresp_o=2'b11, rid_o=captured ID.
  - rlast_o=1 exactly when beat counter == captured len.
  - On rready_i: counter+1. If rlast_o was set → R_IDLE.
  - arlen_i=255 yields 256 beats; the counter never wraps inside a burst.
- Read timing: first rvalid_o is the cycle after the AR handshake. Beats are back-to-back while rready_i=1. Outputs are held stable while rvalid_o=1 and rready_i=0.
- Response outputs: bresp_o/rresp_o are 2'b00 and rid_o/bid_o hold their last value whenever the corresponding valid is low.
- Concurrency: simultaneous AW and AR handshakes are both accepted in the same cycle. One outstanding transaction per channel.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro: DEFAULT_SLAVE_ERR_LOG_EN.
- With the macro defined, the block adds:
  - Output err_addr_o [AddrWidth]: loaded with the address on every accepted AW or AR. If both are accepted in the same cycle, the AW address wins.
  - Output err_cnt_o [CntWidth]: increments by the number of address handshakes that cycle (0/1/2) and saturates at all-ones.
  - Both outputs reset to 0.
- Without the macro: these ports do not exist, awaddr_i/araddr_i are unused, and no log registers are generated.

Test Plan:
- AW id=3 len=3, 4 W beats with WLAST on the 4th, bready_i=1 → wready_o high 4 cycles; bvalid_o the cycle after WLAST with bid_o=3, bresp_o=2'b11.
- AR id=5 len=7, rready_i=1 → 8 consecutive beats, rid_o=5, rdata_o=0, rresp_o=2'b11, rlast_o only on beat 8; arready_o=1 the following cycle.
- AR len=0 with rready_i toggling 0,0,1 → single beat with rlast_o=1, held stable for 3 cycles, consumed on the third.
- W beats presented before AW, then AW id=1; hold bready_i=0 for 5 cycles → wready_o=0 until the cycle after AW; bvalid_o held 5 cycles; awready_o=0 until the B handshake.
- Simultaneous AW id=2 and AR id=9 len=1 → both accepted the same cycle; B and R complete independently with correct IDs. With DEFAULT_SLAVE_ERR_LOG_EN: err_cnt_o=2, err_addr_o equals AW address.
- rst_ni=0 during R_DATA beat 2 of 4 → next cycle rvalid_o=0, arready_o=1, awready_o=1; no further R beats.
